// File: rtl/nn_infer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_infer_sequencer
//
// Avalon-MM slave that owns the 64-word feature buffer feeding the
// combinational neural_net. It runs one inference per START. NN_X is held
// stable for SETTLE_CYCLES, the N_OUT outputs are captured, and a serial signed
// argmax picks the winning class. BUSY/DONE/ERR status and the result are
// exposed to software.
//
// Optional feature: define NN_SEQ_IRQ_EN to get the IRQ output and the CTRL
// IRQ_ENA bit. Without the macro there is no IRQ port, and CTRL bit1 reads 0.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   AVL_CS/READ/WRITE Avalon-MM strobes (ignored while AVL_CS is low)
//   AVL_BYTE_EN       byte enables (FEAT merge; byte 0 gates CTRL/STATUS)
//   AVL_ADDR          word address: 0..63 FEAT, 64..71 OUT, 72 CTRL,
//                     73 STATUS, 74 RESULT, 75..127 read 0
//   AVL_WRITEDATA     write data
//   AVL_READDATA      registered read data, latency 1
//   NN_X              flattened feature vector, word i = [i*DW +: DW]
//   NN_O              flattened neural_net outputs, word k = [k*DW +: DW]
//   IRQ               DONE & IRQ_ENA, registered (NN_SEQ_IRQ_EN only)
// -----------------------------------------------------------------------------
module nn_infer_sequencer #(
  parameter int N_IN          = 64,
  parameter int N_OUT         = 8,
  parameter int DW            = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic                AVL_CS,
  input  logic [3:0]          AVL_BYTE_EN,
  input  logic [6:0]          AVL_ADDR,
  input  logic [31:0]         AVL_WRITEDATA,
  output logic [31:0]         AVL_READDATA,
  output logic [N_IN*DW-1:0]  NN_X,
  input  logic [N_OUT*DW-1:0] NN_O
`ifdef NN_SEQ_IRQ_EN
  ,
  output logic                IRQ
`endif
);

  localparam int CNT_W = 8;
  localparam int K_W   = $clog2(N_OUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_ARGMAX,
    S_FINISH
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [DW-1:0] r_feat [N_IN];
  logic signed [DW-1:0] r_out  [N_OUT];   // software-visible snapshot
  logic signed [DW-1:0] r_snap [N_OUT];   // working copy used by the argmax
  logic signed [DW-1:0] r_best;
  logic [CNT_W-1:0]     r_cnt;
  logic [K_W-1:0]       r_k;
  logic [K_W-1:0]       r_idx_run;
  logic [K_W-1:0]       r_res_idx;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_err;
  logic [31:0]          r_rdata;
  logic [31:0]          w_rdata;

  logic w_wr, w_rd, w_busy, w_feat_wr, w_ctrl_wr, w_stat_wr;
  logic w_start, w_start_err, w_finish, w_gt;
  logic w_done_nxt, w_err_nxt;

`ifdef NN_SEQ_IRQ_EN
  logic r_ena, r_irq, w_ena_nxt;
`endif

  // Merge the enabled bytes of a new word into the stored word.
  function automatic logic signed [DW-1:0] merge_bytes(
    input logic signed [DW-1:0] old_w,
    input logic [31:0]          new_w,
    input logic [3:0]           be
  );
    logic signed [DW-1:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return m;
  endfunction

  assign w_wr        = AVL_CS & AVL_WRITE;
  assign w_rd        = AVL_CS & AVL_READ;
  assign w_busy      = (r_state != S_IDLE);
  assign w_feat_wr   = w_wr & ~AVL_ADDR[6];
  assign w_ctrl_wr   = w_wr & (AVL_ADDR == 7'd72) & AVL_BYTE_EN[0];
  assign w_stat_wr   = w_wr & (AVL_ADDR == 7'd73) & AVL_BYTE_EN[0];
  assign w_start     = w_ctrl_wr & AVL_WRITEDATA[0] & ~w_busy;
  assign w_start_err = w_ctrl_wr & AVL_WRITEDATA[0] & w_busy;
  assign w_finish    = (r_state == S_FINISH);
  assign w_gt        = (r_snap[r_k] > r_best);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_SETTLE;
      S_SETTLE:  if (r_cnt == CNT_LAST) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_ARGMAX;
      S_ARGMAX:  if (r_k == K_LAST) w_state_nxt = S_FINISH;
      S_FINISH:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Clears are applied first so a simultaneous set always wins.
  always_comb begin
    w_done_nxt = r_done;
    if (w_stat_wr && AVL_WRITEDATA[1]) w_done_nxt = 1'b0;
    if (w_start) w_done_nxt = 1'b0;
    if (w_finish) w_done_nxt = 1'b1;
    w_err_nxt = r_err;
    if (w_stat_wr && AVL_WRITEDATA[2]) w_err_nxt = 1'b0;
    if ((w_feat_wr && w_busy) || w_start_err) w_err_nxt = 1'b1;
  end

`ifdef NN_SEQ_IRQ_EN
  always_comb begin
    w_ena_nxt = r_ena;
    if (w_ctrl_wr) w_ena_nxt = AVL_WRITEDATA[1];
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (!AVL_ADDR[6]) begin
      w_rdata = r_feat[AVL_ADDR[5:0]];
    end else if (AVL_ADDR[5:3] == 3'b000) begin
      w_rdata = r_out[AVL_ADDR[2:0]];
    end else begin
      case (AVL_ADDR)
`ifdef NN_SEQ_IRQ_EN
        7'd72:   w_rdata = {30'b0, r_ena, 1'b0};
`endif
        7'd73:   w_rdata = {29'b0, r_err, r_done, w_busy};
        7'd74:   w_rdata = {r_valid, {(31-K_W){1'b0}}, r_res_idx};
        default: w_rdata = '0;
      endcase
    end
  end

  // Control stage: FSM, counters, status and result registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_res_idx <= '0;
      r_idx_run <= '0;
      r_cnt     <= '0;
      r_k       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_start) begin
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      case (r_state)
        S_CAPTURE: begin
          r_idx_run <= '0;
          r_k       <= K_W'(1);
        end
        S_ARGMAX: begin
          if (w_gt) r_idx_run <= r_k;
          r_k <= r_k + K_W'(1);
        end
        S_FINISH: begin
          r_res_idx <= r_idx_run;
          r_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef NN_SEQ_IRQ_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ena <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ena <= w_ena_nxt;
      r_irq <= w_done_nxt & w_ena_nxt;
    end
  end

  assign IRQ = r_irq;
`endif

  // Register-file stage: feature buffer, published outputs, read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N_IN; i++) r_feat[i] <= '0;
      for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
      r_rdata <= '0;
    end else begin
      if (w_feat_wr && !w_busy) begin
        r_feat[AVL_ADDR[5:0]] <= merge_bytes(r_feat[AVL_ADDR[5:0]], AVL_WRITEDATA, AVL_BYTE_EN);
      end
      // OUT keeps its previous contents until the new result is published.
      if (w_finish) begin
        for (int k = 0; k < N_OUT; k++) r_out[k] <= r_snap[k];
      end
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  // Capture/argmax stage: working datapath, always loaded before use
  always_ff @(posedge CLK) begin
    if (r_state == S_CAPTURE) begin
      for (int k = 0; k < N_OUT; k++) r_snap[k] <= NN_O[k*DW +: DW];
      r_best <= NN_O[DW-1:0];
    end else if (r_state == S_ARGMAX && w_gt) begin
      r_best <= r_snap[r_k];
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_nnx
    assign NN_X[gi*DW +: DW] = r_feat[gi];
  end

  assign AVL_READDATA = r_rdata;

endmodule
